// File: rtl/quant_zigzag_reorder.sv
// Ping-pong 8x8 reorder buffer: raster in, JPEG zigzag out.
// Optional saturation on write when ZIGZAG_SAT_EN is defined.
module quant_zigzag_reorder #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [5:0]       out_index,
  output logic             out_last,
  output logic             out_sat
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [OUT_W-1:0] mem [2][64];
  logic [1:0]       full, full_n;
  logic             wr_bank, rd_bank;
  logic [5:0]       wr_cnt, rd_cnt;
  logic             wr_en, rd_en;
  logic [OUT_W-1:0] w_data;
  logic [5:0]       rd_addr;

  assign in_ready  = !full[wr_bank] && !rst;
  assign wr_en     = in_valid && in_ready;
  assign out_valid = full[rd_bank];
  assign rd_en     = out_valid && out_ready;
  assign rd_addr   = ZZ[rd_cnt];
  assign out_data  = mem[rd_bank][rd_addr];
  assign out_index = rd_cnt;
  assign out_last  = out_valid && (rd_cnt == 6'd63);

`ifdef ZIGZAG_SAT_EN
  localparam logic signed [IN_W-1:0] S_MAX =
    {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] S_MIN =
    {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [63:0] sat_mem [2];
  logic        s_hi, s_lo, w_sat;

  always_comb begin
    s_hi  = $signed(in_data) > S_MAX;
    s_lo  = $signed(in_data) < S_MIN;
    w_sat = s_hi || s_lo;
    if (s_hi)      w_data = S_MAX[OUT_W-1:0];
    else if (s_lo) w_data = S_MIN[OUT_W-1:0];
    else           w_data = in_data[OUT_W-1:0];
  end

  assign out_sat = sat_mem[rd_bank][rd_addr];

  always_ff @(posedge clk) begin
    if (rst)
      sat_mem <= '{default: '0};
    else if (wr_en)
      sat_mem[wr_bank][wr_cnt] <= w_sat;
  end
`else
  function automatic logic [OUT_W-1:0] narrow(
    input logic [IN_W-1:0] x
  );
    return x[OUT_W-1:0];
  endfunction

  assign w_data  = narrow(in_data);
  assign out_sat = 1'b0;
`endif

  // Set and clear always hit different banks: writes never target a full one.
  always_comb begin
    full_n = full;
    if (wr_en && wr_cnt == 6'd63) full_n[wr_bank] = 1'b1;
    if (rd_en && rd_cnt == 6'd63) full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= 6'd0;
      rd_bank <= 1'b0;
      rd_cnt  <= 6'd0;
      full    <= 2'b00;
      mem     <= '{default: '0};
    end else begin
      full <= full_n;
      if (wr_en) begin
        mem[wr_bank][wr_cnt] <= w_data;
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_cnt == 6'd63) wr_bank <= ~wr_bank;
      end
      if (rd_en) begin
        rd_cnt <= rd_cnt + 6'd1;
        if (rd_cnt == 6'd63) rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: doc/quant_zigzag_reorder.md
# quant_zigzag_reorder

Ping-pong reorder buffer directly downstream of the quantization multiplier. It accepts quantized DCT coefficients one per cycle in raster order, with 64 per 8x8 block. Each coefficient is narrowed to the entropy-coder width. Coefficients leave in JPEG zigzag order on a valid/ready stream, and two banks let one block be written while the previous one is read.

## Interface
Parameters:
- IN_W, 32, width of the signed quantized coefficient from the multiplier stage
- OUT_W, 16, width of the signed coefficient stored and emitted (OUT_W <= IN_W)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input coefficient valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  IN_W  signed coefficient, raster order
- out_valid  out  1  output coefficient valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_W  signed coefficient, zigzag order
- out_index  out  6  zigzag position k (0..63) of out_data
- out_last  out  1  high with k=63
- out_sat  out  1  current out_data was clamped (0 when saturation compiled out)

## Operation
- Storage: two banks of 64 x OUT_W flops, bank b has flag full[b].
- Write side: wr_bank (1 b) and wr_cnt (6 b). in_ready = !full[wr_bank] && !rst.
  - Accept on in_valid && in_ready: store narrowed in_data at raster address wr_cnt, wr_cnt++.
  - On accept with wr_cnt==63: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read side: rd_bank (1 b) and rd_cnt (6 b). out_valid = full[rd_bank].
  - out_data = bank[rd_bank][ZZ[rd_cnt]], combinational from flops. out_index = rd_cnt.
  - Beat on out_valid && out_ready: rd_cnt++.
  - On beat with rd_cnt==63: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
- ZZ is a constant table giving the raster address for zigzag position k. It is standard JPEG order: 0,1,8,16,9,2,3,10,17,24,… ending …,61,54,47,55,62,63.
- Outputs hold stable while out_valid && !out_ready.
- Simultaneous events: the write of the last word of bank A and the read of the last word of bank B in the same cycle are independent, with separate full flags and no conflict. Writing never targets a full bank, so no read/write hazard exists.
- Reset (any cycle, including mid-block) has the following effect:
  - all counters, bank pointers and full flags go to 0;
  - the partial block is discarded;
  - bank contents are cleared to 0.

## Timing
- Reset values: in_ready=0 while rst=1 and 1 the cycle after. out_valid=0, out_data=0, out_index=0, out_last=0, out_sat=0.
- Latency: out_valid rises in the cycle after the clock edge that accepted raster word 63. That is 1 cycle from the last input to the first output.
- Throughput: 1 coefficient/cycle sustained with in_valid=1 and out_ready=1, with no bubbles between blocks.
- Backpressure: with out_ready=0, at most 128 coefficients are accepted before in_ready falls. in_ready returns to 1 in the cycle after the beat that completes the reading of a bank.

## Configuration
- ZIGZAG_SAT_EN defined:
  - in_data is saturated to the OUT_W signed range on write: > 2^(OUT_W-1)-1 becomes max, < -2^(OUT_W-1) becomes min.
  - One extra sat bit is stored per entry and emitted on out_sat.
- ZIGZAG_SAT_EN undefined:
  - in_data[OUT_W-1:0] is stored (plain truncation) and no sat bits exist.
  - out_sat is tied to 0.

## Test plan
- Single block, in_data = raster index 0..63, out_ready=1 -> out_data = 0,1,8,16,9,2,3,10,… ending 47,55,62,63. out_last only on the 64th beat. out_valid first high 1 cycle after the 64th accept.
- Three blocks back-to-back with out_ready=1 -> in_ready never drops after reset. 192 outputs with no gaps after the initial 1-cycle latency. Each block is correctly reordered.
- out_ready=0 held -> in_ready=0 after 128 accepts and the 129th word is not accepted. With out_ready=1, in_ready returns the cycle after output beat k=63 of bank 0.
- OUT_W=16, in_data=70000 and -70000 at raster 0 and 1:
  - with ZIGZAG_SAT_EN: outputs 32767 and -32768, out_sat=1 on both;
  - without: outputs 4464 and -4464, out_sat=0.
- rst asserted after 30 accepted inputs -> out_valid=0 and in_ready=0 during reset. The next 64 inputs form a fresh block, with output order starting at that block's raster 0.
- Random in_valid/out_ready throttling over 50 blocks -> output stream matches the reference zigzag model exactly, with no loss and no duplication.
